auto_count_ctrl: RTL and testbench
==================================

Name: auto_count_ctrl

Overview:
Upstream stage of the seven-segment decoder. Generates the 4-bit BCD digit `count` that the decoder displays. The digit auto-increments or auto-decrements at a prescaled rate. A single debounced pushbutton starts and stops counting, and a synchronous clear is provided. Also produces a one-cycle wrap pulse for cascading a second digit.

Parameters:
TICK_DIV, 50000000, clk cycles per count step; minimum 2
DB_CYCLES, 500000, consecutive stable cycles required to accept a button level change; minimum 1
MAX_VAL, 9, highest digit value; 1..15; count range is 0..MAX_VAL

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-low reset
btn_n  input  1  raw start/stop pushbutton, active-low, asynchronous to clk
dir  input  1  1 = count up, 0 = count down; sampled at each step
clr  input  1  synchronous active-high clear of digit and prescaler
count  output  4  current digit, 0..MAX_VAL
wrap  output  1  one-cycle pulse on a wrap step (MAX_VAL->0 up, 0->MAX_VAL down)
running  output  1  1 while the state machine is in RUN

Behaviour:
Reset (rst=0, asynchronous):
- count=0, wrap=0, running=0, state=STOP, prescaler=0.
- Synchroniser flops = 1 (released). Debounced level = 1. Debounce counter = 0.
- Release is not required to align with a clock edge. The first active edge after release behaves as normal operation.

Button path:
- 2-flop synchroniser on btn_n.
- Debounce counter increments while the synchronised level differs from the debounced level. It clears to 0 when the levels match.
- On reaching DB_CYCLES-1 while still differing, the debounced level takes the synchronised value and the counter clears.
- A press event is a 1->0 transition of the debounced level: one cycle, internal.
- Latency from a stable btn_n low to the press event: 2 sync cycles + DB_CYCLES cycles.
- Releasing the button generates no event. Holding it generates exactly one event.

State machine (two states):
- STOP: prescaler held at 0, count held. A press event moves to RUN.
- RUN: prescaler counts 0..TICK_DIV-1 and wraps to 0. A tick is asserted in the cycle where prescaler==TICK_DIV-1. A press event moves to STOP.
- A press event and a tick in the same cycle: the tick's step is applied, then the state moves to STOP.
- running = (state==RUN), registered.

Counting, on each tick:
- dir=1: count+1. At MAX_VAL the next value is 0 and wrap=1 for that cycle.
- dir=0: count-1. At 0 the next value is MAX_VAL and wrap=1 for that cycle.
- wrap is registered and aligned with the cycle in which count shows the wrapped value.
- count never leaves 0..MAX_VAL. Values are 4-bit unsigned with no carry beyond bit 3.

Clear:
- clr=1 forces count=0, prescaler=0, wrap=0 on the next edge.
- Clear overrides a coincident tick.
- The state is unchanged: a RUN block keeps running and restarts a full TICK_DIV period.

Reset mid-operation:
- Immediate return to reset values regardless of state.
- A press in progress is discarded.

Test Plan:
1. Reset release, then hold btn_n=0 (TICK_DIV=4, DB_CYCLES=3) -> running=1 exactly 2+3+1 cycles after btn_n falls, and count reaches 1 four cycles later.
2. RUN with dir=1 from count=0 for 40 cycles -> count steps 0..9 every 4 cycles, then 9->0 with a single-cycle wrap=1 coincident with count=0.
3. RUN with dir=0 from count=0 -> next tick gives count=9 with wrap=1, then 8, 7, ...
4. btn_n bounce (0 for 2 cycles, 1 for 1 cycle, repeated 5 times), then stable 0 -> exactly one press event. Holding btn_n low for 100 cycles leaves running unchanged after the first toggle.
5. clr=1 asserted on the same cycle as a tick with count=5 -> count=0 and wrap=0 next cycle, running stays 1, and the next step occurs 4 cycles after clr deasserts.
6. rst pulled low mid-RUN at count=7 -> count=0, running=0, wrap=0 immediately (asynchronous). A second press after release restarts counting from 0.

Source files
------------

// File: rtl/auto_count_ctrl.sv
// Auto-incrementing/decrementing BCD digit source for the seven-segment decoder.
// A debounced start/stop button drives a two-state run controller; the digit steps once per prescaler period.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_STOP | prescaler held at 0, digit frozen
// ST_RUN  | prescaler free-runs, digit steps on each tick
module auto_count_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned MAX_VAL   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] count,
    output logic       wrap,
    output logic       running
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [3:0]    MAX_DIGIT  = 4'(MAX_VAL);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          db_level_q;
    logic          db_level_d;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          press_q;
    logic          press_d;
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [3:0]    count_q;
    logic [3:0]    count_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing cycles;
    // only the falling (pressed) acceptance produces an event.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                press_d    = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        count_d = count_q;
        wrap_d  = 1'b0;
        tick    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

        if ((state_q == ST_RUN) && !tick) begin
            presc_d = presc_q + PW'(1);
        end

        if (tick) begin
            if (dir) begin
                if (count_q >= MAX_DIGIT) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if (count_q == 4'd0) begin
                    count_d = MAX_DIGIT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end

        // Clear wins over a coincident tick but leaves the run state alone.
        if (clr) begin
            count_d = '0;
            presc_d = '0;
            wrap_d  = 1'b0;
        end

        if (press_q) begin
            if (state_q == ST_STOP) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_STOP;
                presc_d = '0;
            end
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_auto_count_ctrl.sv
// Scoreboard bench for auto_count_ctrl: a per-edge reference model queues expected outputs,
// a negedge monitor pops and compares; directed checks cover latency, clear and async reset.
module tb_auto_count_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int MAX_VAL   = 9;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       btn_n = 1'b1;
    logic       dir   = 1'b1;
    logic       clr   = 1'b0;
    logic [3:0] count;
    logic       wrap;
    logic       running;

    auto_count_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .MAX_VAL  (MAX_VAL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .dir    (dir),
        .clr    (clr),
        .count  (count),
        .wrap   (wrap),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] count;
        logic       wrap;
        logic       running;
    } obs_t;

    obs_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   run_toggles = 0;
    int   wraps_seen  = 0;
    logic last_running = 1'b0;

    // Reference model state: raw button history, debounced level, run flag, digit.
    int m_count;
    int m_phase;
    int m_diff;
    bit m_wrap;
    bit m_running;
    bit m_db;
    bit m_h1;
    bit m_h2;
    bit m_press_pend;

    function void model_reset();
        m_count      = 0;
        m_phase      = 0;
        m_diff       = 0;
        m_wrap       = 0;
        m_running    = 0;
        m_db         = 1;
        m_h1         = 1;
        m_h2         = 1;
        m_press_pend = 0;
    endfunction

    function void model_edge();
        bit s;
        bit press_now;
        s            = m_h2;
        m_h2         = m_h1;
        m_h1         = btn_n;
        press_now    = m_press_pend;
        m_press_pend = 0;
        if (s != m_db) begin
            m_diff++;
            if (m_diff == DB_CYCLES) begin
                m_db         = s;
                m_diff       = 0;
                m_press_pend = (s == 0);
            end
        end else begin
            m_diff = 0;
        end
        m_wrap = 0;
        if (clr) begin
            m_count = 0;
            m_phase = 0;
        end else if (m_running) begin
            if (m_phase == TICK_DIV - 1) begin
                m_phase = 0;
                if (dir) begin
                    m_wrap  = (m_count == MAX_VAL);
                    m_count = (m_count + 1) % (MAX_VAL + 1);
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + MAX_VAL) % (MAX_VAL + 1);
                end
            end else begin
                m_phase++;
            end
        end
        if (press_now) begin
            m_running = !m_running;
            m_phase   = 0;
        end
        exp_q.push_back({4'(m_count), m_wrap, m_running});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {count, wrap, running};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t count=%0d exp=%0d wrap=%0b exp=%0b running=%0b exp=%0b",
                         $time, a.count, e.count, a.wrap, e.wrap, a.running, e.running);
            end
            if (running !== last_running) run_toggles++;
            if (wrap === 1'b1) wraps_seen++;
            last_running = running;
        end
    end

    initial begin
        int lat;
        int n;
        int t0;
        int seg;
        model_reset();

        #10;
        chk("reset_count", count, 0);
        chk("reset_running", running, 0);
        chk("reset_wrap", wrap, 0);
        #13 rst = 1'b1;

        // Press-to-run latency and first step.
        repeat (3) step();
        btn_n = 1'b0;
        dir   = 1'b1;
        lat   = 0;
        while (running !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("press_latency", lat, 6);
        repeat (4) step();
        chk("first_step_count", count, 1);

        // Up count through a wrap.
        wraps_seen = 0;
        repeat (40) step();
        @(negedge clk);
        #1;
        chk("up_wrap_pulses", wraps_seen, 1);
        chk("up_final_count", count, 1);

        // Down count through 0 -> MAX_VAL.
        dir = 1'b0;
        repeat (20) step();

        // Bounce then stable press: exactly one toggle.
        btn_n = 1'b1;
        repeat (10) step();
        @(negedge clk);
        #1;
        t0 = run_toggles;
        for (int r = 0; r < 5; r++) begin
            btn_n = 1'b0;
            repeat (2) step();
            btn_n = 1'b1;
            step();
        end
        btn_n = 1'b0;
        repeat (100) step();
        @(negedge clk);
        #1;
        chk("bounce_single_toggle", run_toggles - t0, 1);

        // Restart, clear coincident with a tick at count 5.
        btn_n = 1'b1;
        repeat (10) step();
        btn_n = 1'b0;
        dir   = 1'b1;
        n     = 0;
        while (!(m_running && m_count == 5 && m_phase == 0) && n < 200) begin
            step();
            n++;
        end
        chk("reach_count5", (n < 200) ? 1 : 0, 1);
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_wrap", wrap, 0);
        chk("clr_running", running, 1);
        repeat (3) step();
        chk("clr_hold_count", count, 0);
        step();
        chk("clr_next_step", count, 1);

        // Asynchronous reset mid-run at count 7.
        n = 0;
        while (m_count != 7 && n < 200) begin
            step();
            n++;
        end
        chk("reach_count7", (n < 200) ? 1 : 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_wrap", wrap, 0);
        exp_q.delete();
        model_reset();
        btn_n = 1'b1;
        #17 rst = 1'b1;
        repeat (5) step();
        btn_n = 1'b0;
        lat   = 0;
        while (running !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("restart_latency", lat, 6);
        chk("restart_count", count, 0);
        repeat (4) step();
        chk("restart_first_step", count, 1);

        // Randomized button segments, direction and clear.
        for (int k = 0; k < 60; k++) begin
            btn_n = 1'($urandom_range(0, 1));
            seg   = $urandom_range(1, 14);
            for (int j = 0; j < seg; j++) begin
                dir = 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        clr = 1'b0;
        repeat (5) step();
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
